// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and the memory stage.
// Fetch and single-word accesses take 2 cycles; two-word bursts take 3 cycles.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  output logic                stall_if,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic                mem_burst,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [2*DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_ack,
  output logic                ram_en,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic [1:0]          fsm_state,
  output logic                last_mem
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IF_ACC   = 2'd1,
    MEM_ACC  = 2'd2,
    MEM_ACC2 = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t state, state_nxt;
  logic   last_mem_nxt;
  logic   grant_mem;

  // MEM wins a tie unless it already won the previous tie, so fetch waits at most one MEM transaction.
  assign grant_mem = mem_req && !(if_req && last_mem);
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      last_mem <= 1'b0;
    end else begin
      state    <= state_nxt;
      last_mem <= last_mem_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    last_mem_nxt = last_mem;
    if_ack       = 1'b0;
    if_rdata     = '0;
    mem_ack      = 1'b0;
    mem_rdata    = '0;
    ram_en       = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = '0;
    ram_wdata    = '0;
    case (state)
      IDLE: begin
        if (mem_req || if_req) begin
          ram_en = 1'b1;
          if (grant_mem) begin
            ram_we    = mem_we;
            ram_addr  = mem_addr;
            ram_wdata = mem_wdata[DATA_W-1:0];
            state_nxt = MEM_ACC;
            if (if_req) last_mem_nxt = 1'b1;
          end else begin
            ram_addr     = if_addr;
            state_nxt    = IF_ACC;
            last_mem_nxt = 1'b0;
          end
        end
      end
      IF_ACC: begin
        if_ack    = 1'b1;
        if_rdata  = ram_rdata;
        state_nxt = IDLE;
      end
      MEM_ACC: begin
        mem_ack = 1'b1;
        if (!mem_we) mem_rdata = ram_rdata;
        // The second burst word is issued while the first one is being acknowledged.
        if (mem_burst) begin
          ram_en    = 1'b1;
          ram_we    = mem_we;
          ram_addr  = mem_addr + ADDR_ONE;
          ram_wdata = mem_wdata[2*DATA_W-1:DATA_W];
          state_nxt = MEM_ACC2;
        end else begin
          state_nxt = IDLE;
        end
      end
      MEM_ACC2: begin
        mem_ack = 1'b1;
        if (!mem_we) mem_rdata = ram_rdata;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!rst) begin
      if_ack    = 1'b0;
      if_rdata  = '0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
    end
    stall_if = if_req && !if_ack;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RAM peripheral, transaction-level reference model checked
// every cycle, and directed scenarios with hand-computed expectations.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic [15:0] if_rdata;
  logic        if_ack;
  logic        stall_if;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic        mem_burst = 1'b0;
  logic [15:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        ram_en;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata = '0;
  logic [1:0]  fsm_state;
  logic        last_mem;

  int total = 0;
  int bad = 0;
  logic started = 1'b0;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .stall_if(stall_if),
    .mem_req(mem_req), .mem_we(mem_we), .mem_burst(mem_burst), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .fsm_state(fsm_state), .last_mem(last_mem)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Initial memory image: every word is addr^5A5A except one preloaded fetch word.
  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hABCD : (a ^ 16'h5A5A);
  endfunction

  // RAM peripheral
  logic [15:0] ram_w [int];
  function automatic logic [15:0] ram_peek(input logic [15:0] a);
    return ram_w.exists(int'(a)) ? ram_w[int'(a)] : init_val(a);
  endfunction
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_w[int'(ram_addr)] = ram_wdata;
      else ram_rdata <= ram_peek(ram_addr);
    end
  end

  // Reference model: one transaction in flight, phase counts its ack cycles.
  int          m_phase = 0;
  logic        m_is_mem = 1'b0;
  logic        m_last_mem = 1'b0;
  logic [15:0] m_addr = '0;
  logic        m_we = 1'b0;
  logic        m_burst = 1'b0;
  logic [31:0] m_wdata = '0;
  logic [15:0] model_mem [int];

  function automatic logic [15:0] mm_rd(input logic [15:0] a);
    return model_mem.exists(int'(a)) ? model_mem[int'(a)] : init_val(a);
  endfunction

  function automatic logic pick_mem();
    return mem_req && !(if_req && m_last_mem);
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_phase    <= 0;
      m_last_mem <= 1'b0;
    end else if (m_phase == 0) begin
      if (if_req || mem_req) begin
        m_phase  <= 1;
        m_is_mem <= pick_mem();
        if (pick_mem()) begin
          m_addr  <= mem_addr;
          m_we    <= mem_we;
          m_burst <= mem_burst;
          m_wdata <= mem_wdata;
          if (mem_we) model_mem[int'(mem_addr)] = mem_wdata[15:0];
          if (if_req) m_last_mem <= 1'b1;
        end else begin
          m_addr     <= if_addr;
          m_last_mem <= 1'b0;
        end
      end
    end else if (m_phase == 1 && m_is_mem && m_burst) begin
      m_phase <= 2;
      if (m_we) model_mem[int'(m_addr + 16'd1)] = m_wdata[31:16];
    end else begin
      m_phase <= 0;
    end
  end

  // scoreboard: compare DUT outputs with the model every cycle
  always @(negedge clk) begin
    logic        e_if_ack, e_mem_ack, e_ram_en, e_ram_we, e_pm;
    logic [15:0] e_if_rdata, e_mem_rdata, e_ram_addr, e_ram_wdata;
    if (started) begin
      e_if_ack = 0; e_mem_ack = 0; e_ram_en = 0; e_ram_we = 0; e_pm = 0;
      e_if_rdata = '0; e_mem_rdata = '0; e_ram_addr = '0; e_ram_wdata = '0;
      if (rst) begin
        if (m_phase == 0) begin
          if (if_req || mem_req) begin
            e_pm        = pick_mem();
            e_ram_en    = 1'b1;
            e_ram_addr  = e_pm ? mem_addr : if_addr;
            e_ram_we    = e_pm && mem_we;
            e_ram_wdata = e_pm ? mem_wdata[15:0] : 16'h0;
          end
        end else if (!m_is_mem) begin
          e_if_ack   = 1'b1;
          e_if_rdata = mm_rd(m_addr);
        end else if (m_phase == 1) begin
          e_mem_ack   = 1'b1;
          e_mem_rdata = mm_rd(m_addr);
          if (m_burst) begin
            e_ram_en    = 1'b1;
            e_ram_we    = m_we;
            e_ram_addr  = m_addr + 16'd1;
            e_ram_wdata = m_wdata[31:16];
          end
        end else begin
          e_mem_ack   = 1'b1;
          e_mem_rdata = mm_rd(m_addr + 16'd1);
        end
        chk("sb_if_ack", if_ack, e_if_ack);
        chk("sb_mem_ack", mem_ack, e_mem_ack);
        chk("sb_ram_en", ram_en, e_ram_en);
        chk("sb_ram_we", ram_we, e_ram_we);
        chk("sb_stall_if", stall_if, if_req && !e_if_ack);
        chk("sb_last_mem", last_mem, m_last_mem);
        if (e_ram_en) chk("sb_ram_addr", ram_addr, e_ram_addr);
        if (e_ram_en && e_ram_we) chk("sb_ram_wdata", ram_wdata, e_ram_wdata);
        if (e_if_ack) chk("sb_if_rdata", if_rdata, e_if_rdata);
        if (e_mem_ack && !m_we) chk("sb_mem_rdata", mem_rdata, e_mem_rdata);
      end else begin
        chk("sb_rst_outs", {if_ack, mem_ack, ram_en, ram_we}, 32'h0);
        chk("sb_rst_buses", {ram_addr, ram_wdata}, 32'h0);
        chk("sb_rst_rdata", {if_rdata, mem_rdata}, 32'h0);
        chk("sb_rst_stall", stall_if, if_req);
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic look();
    @(negedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  logic [15:0] grant_addr [4];
  int n_grant;
  int n_bad_idle;

  initial begin
    // reset
    repeat (3) @(posedge clk);
    started = 1'b1;
    look();
    chk("reset_ram_en", ram_en, 0);
    chk("reset_acks", {if_ack, mem_ack}, 0);
    chk("reset_state", fsm_state, 0);
    chk("reset_last_mem", last_mem, 0);
    step(); rst = 1'b1;

    // fetch read
    step(); if_req = 1'b1; if_addr = 16'h0010;
    look();
    chk("fetch_c0_ram_en", ram_en, 1);
    chk("fetch_c0_stall", stall_if, 1);
    chk("fetch_c0_addr", ram_addr, 16'h0010);
    step(); look();
    chk("fetch_c1_ack", if_ack, 1);
    chk("fetch_c1_rdata", if_rdata, 16'hABCD);
    chk("fetch_c1_stall", stall_if, 0);
    step(); if_req = 1'b0;

    // simultaneous requests, MEM first
    if_req = 1'b1; if_addr = 16'h0020;
    mem_req = 1'b1; mem_we = 1'b1; mem_burst = 1'b0; mem_addr = 16'h0030; mem_wdata = 32'h0000_1234;
    look();
    chk("both_c0_addr", ram_addr, 16'h0030);
    chk("both_c0_we", ram_we, 1);
    step(); look();
    chk("both_c1_mem_ack", mem_ack, 1);
    chk("both_c1_if_ack", if_ack, 0);
    step(); mem_req = 1'b0; mem_we = 1'b0;
    look();
    chk("both_c2_if_grant", {fsm_state, ram_en, ram_we}, {2'd0, 1'b1, 1'b0});
    chk("both_c2_addr", ram_addr, 16'h0020);
    step(); look();
    chk("both_c3_if_ack", if_ack, 1);
    chk("both_c3_if_rdata", if_rdata, 16'h5A7A);
    step(); if_req = 1'b0;
    look();
    chk("both_last_mem", last_mem, 0);
    chk("both_ram_0030", ram_peek(16'h0030), 16'h1234);

    // burst push with address wrap
    step();
    mem_req = 1'b1; mem_we = 1'b1; mem_burst = 1'b1; mem_addr = 16'hFFFF; mem_wdata = 32'h0040_1000;
    look();
    chk("push_c0_addr", ram_addr, 16'hFFFF);
    chk("push_c0_wdata", ram_wdata, 16'h1000);
    chk("push_c0_if_ack", if_ack, 0);
    step(); look();
    chk("push_c1_mem_ack", mem_ack, 1);
    chk("push_c1_addr", ram_addr, 16'h0000);
    chk("push_c1_wdata", ram_wdata, 16'h0040);
    chk("push_c1_en_we", {ram_en, ram_we}, 2'b11);
    chk("push_c1_if_ack", if_ack, 0);
    step(); look();
    chk("push_c2_mem_ack", mem_ack, 1);
    chk("push_c2_ram_en", ram_en, 0);
    chk("push_c2_if_ack", if_ack, 0);
    step(); mem_req = 1'b0; mem_burst = 1'b0; mem_we = 1'b0;
    look();
    chk("push_c3_mem_ack", mem_ack, 0);
    chk("push_ram_ffff", ram_peek(16'hFFFF), 16'h1000);
    chk("push_ram_0000", ram_peek(16'h0000), 16'h0040);

    // fairness with both requesters held
    step();
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h0200;
    if_req = 1'b1; if_addr = 16'h0300;
    n_grant = 0;
    for (int c = 0; c < 24 && n_grant < 4; c++) begin
      look();
      if (fsm_state == 2'd0 && ram_en) begin
        grant_addr[n_grant] = ram_addr;
        n_grant++;
      end
      step();
    end
    chk("fair_count", n_grant, 4);
    chk("fair_g0", grant_addr[0], 16'h0200);
    chk("fair_g1", grant_addr[1], 16'h0300);
    chk("fair_g2", grant_addr[2], 16'h0200);
    chk("fair_g3", grant_addr[3], 16'h0300);
    step(); if_req = 1'b0;
    step();
    step(); mem_req = 1'b0;

    // burst read interrupted by reset
    mem_req = 1'b1; mem_we = 1'b0; mem_burst = 1'b1; mem_addr = 16'h0100;
    look();
    chk("rburst_c0_addr", ram_addr, 16'h0100);
    step(); rst = 1'b0;
    look();
    chk("rburst_c1_mem_ack", mem_ack, 0);
    chk("rburst_c1_ram_en", ram_en, 0);
    step(); mem_req = 1'b0; mem_burst = 1'b0;
    look();
    chk("rburst_c2_state", fsm_state, 0);
    chk("rburst_c2_outs", {if_ack, mem_ack, ram_en, ram_we}, 0);
    chk("rburst_c2_buses", {ram_addr, ram_wdata, if_rdata, mem_rdata}, 0);
    step(); rst = 1'b1;

    // idle
    n_bad_idle = 0;
    for (int c = 0; c < 10; c++) begin
      look();
      if (ram_en || ram_we || if_ack || mem_ack) n_bad_idle++;
      step();
    end
    chk("idle_activity", n_bad_idle, 0);

    // burst read without interruption
    mem_req = 1'b1; mem_we = 1'b0; mem_burst = 1'b1; mem_addr = 16'h0100;
    look();
    chk("bread_c0_en_we", {ram_en, ram_we}, 2'b10);
    step(); look();
    chk("bread_c1_ack", mem_ack, 1);
    chk("bread_c1_rdata", mem_rdata, 16'h5B5A);
    chk("bread_c1_addr", ram_addr, 16'h0101);
    step(); look();
    chk("bread_c2_ack", mem_ack, 1);
    chk("bread_c2_rdata", mem_rdata, 16'h5B5B);
    chk("bread_c2_ram_en", ram_en, 0);
    step(); mem_req = 1'b0; mem_burst = 1'b0;
    look();
    chk("bread_c3_ack", mem_ack, 0);

    repeat (2) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, meaning memory word width.
REQ-003 SHALL have a single clock, and its reset SHALL be synchronous and active-low.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous active-low reset.
REQ-006 if_req  input  1  fetch read request; held with if_addr until if_ack.
REQ-007 if_addr  input  ADDR_W  fetch word address.
REQ-008 if_rdata  output  DATA_W  fetch read data; valid while if_ack=1.
REQ-009 if_ack  output  1  one-cycle fetch completion pulse.
REQ-010 stall_if  output  1  fetch stage must hold its PC.
REQ-011 mem_req  input  1  memory-stage request; held with all mem_* inputs until the final mem_ack.
REQ-012 mem_we  input  1  1=write, 0=read.
REQ-013 mem_burst  input  1  two-word access at mem_addr and mem_addr+1 (PC push/pop on int/ret).
REQ-014 mem_addr  input  ADDR_W  memory-stage word address.
REQ-015 mem_wdata  input  2*DATA_W  write data; low word to mem_addr, high word to mem_addr+1.
REQ-016 mem_rdata  output  DATA_W  read data; valid while mem_ack=1.
REQ-017 mem_ack  output  1  per-word completion pulse.
REQ-018 ram_en, ram_we  output  1 each  RAM strobe and write enable.
REQ-019 ram_addr  output  ADDR_W; ram_wdata  output  DATA_W; ram_rdata  input  DATA_W, valid one cycle after ram_en with ram_we=0.

Function
REQ-020 SHALL implement the FSM states IDLE, IF_ACC, MEM_ACC, and MEM_ACC2.
REQ-021 In IDLE with a request pending, SHALL drive ram_en=1 with the winner's address, write enable, and write data combinationally in that cycle. The FSM SHALL then go to IF_ACC or MEM_ACC.
REQ-022 In IF_ACC, SHALL assert if_ack=1 and set if_rdata=ram_rdata. The FSM SHALL then return to IDLE, giving a throughput of 1 access per 2 cycles.
REQ-023 In MEM_ACC, SHALL assert mem_ack=1 with mem_rdata=ram_rdata for reads.
  - If mem_burst=1: in the same cycle, issue the second word (ram_addr=mem_addr+1, ram_wdata=mem_wdata high word), then go to MEM_ACC2.
  - Otherwise: go to IDLE.
REQ-024 In MEM_ACC2, SHALL assert a second mem_ack pulse carrying the second word. The FSM SHALL then go to IDLE, so a burst completes in 3 cycles with acks on cycles 2 and 3.
REQ-025 Address arithmetic for mem_addr+1 SHALL wrap modulo 2^ADDR_W (all-ones+1 -> 0).
REQ-026 Arbitration when only one requester is pending SHALL grant that requester.
REQ-027 Arbitration when both are pending SHALL grant MEM, unless flag last_mem=1, in which case it SHALL grant IF.
REQ-028 last_mem SHALL be set to 1 on a MEM grant made while if_req=1, and cleared on any IF grant. Consequence: fetch is never starved for more than one MEM transaction.
REQ-029 stall_if SHALL equal if_req AND NOT if_ack, combinationally.
REQ-030 Requests arriving in a non-IDLE state SHALL wait. A grant SHALL never preempt an access in progress.
REQ-031 ram_en SHALL be 0 and ram_we SHALL be 0 in IDLE with no request and in IF_ACC.
REQ-032 A requester dropping req before ack SHALL be outside protocol. Behaviour is undefined, but the FSM SHALL still return to IDLE.

Reset
REQ-033 While rst=0 at a clock edge, the FSM SHALL enter IDLE and last_mem SHALL clear to 0.
REQ-034 While rst=0, all outputs SHALL be 0: if_ack, mem_ack, ram_en, ram_we, ram_addr, ram_wdata, if_rdata, and mem_rdata. stall_if SHALL follow REQ-029.
REQ-035 Reset asserted mid-burst SHALL abandon the second word. No further ack SHALL be issued.
REQ-036 After reset release, the first cycle SHALL be treated as IDLE arbitration.

Verification
REQ-037 Fetch read: RAM[0x0010]=0xABCD, if_req=1, if_addr=0x0010 at cycle 0. Required: ram_en=1 at cycle 0; if_ack=1 with if_rdata=0xABCD at cycle 1; stall_if=1 at cycle 0 and 0 at cycle 1.
REQ-038 Simultaneous requests with last_mem=0: IF read 0x0020 plus MEM write 0x0030=0x1234. Required: MEM is granted first; RAM[0x0030]=0x1234; mem_ack at cycle 1; IF granted at cycle 2 with if_ack at cycle 3; last_mem=0 afterward.
REQ-039 Burst push: mem_burst=1, mem_we=1, mem_addr=0xFFFF, mem_wdata=0x0040_1000. Required: RAM[0xFFFF]=0x1000 and RAM[0x0000]=0x0040; mem_ack at cycles 1 and 2; if_ack=0 throughout.
REQ-040 Fairness: MEM held continuously requesting and IF requesting. Required: grants alternate MEM, IF, MEM, IF; no two consecutive MEM grants while if_req=1.
REQ-041 Burst read with reset: burst read at 0x0100 with rst=0 asserted at cycle 1. Required: at cycle 2 all outputs are 0 and the FSM is in IDLE; no second mem_ack occurs.
REQ-042 Idle: no requests for 10 cycles. Required: ram_en=0, ram_we=0, and no acks throughout.
